// File: rtl/clk_switch_ctrl_pkg.sv
// clk_switch_ctrl_pkg: FSM state encoding and counter sizing for the clock switch controller.
package clk_switch_ctrl_pkg;

   typedef enum logic [2:0] {
      RST_DIV,
      RST_SW,
      RST_CORE,
      IDLE,
      ISSUE,
      DWELL
   } clk_switch_ctrl_state_e;

   function automatic int cnt_width(input int a, input int b, input int c, input int d, input int e);
      int m;
      m = a;
      m = (b > m) ? b : m;
      m = (c > m) ? c : m;
      m = (d > m) ? d : m;
      m = (e > m) ? e : m;
      return $clog2(m) + 1;
   endfunction

   localparam int CNT_W = cnt_width(8, 8, 32, 16, 64);

endpackage

// File: rtl/clk_switch_ctrl_cnt.sv
// clk_switch_ctrl_cnt: loadable down-counter that holds at zero; shared by every timed FSM state.
module clk_switch_ctrl_cnt
   import clk_switch_ctrl_pkg::*;
#(
   parameter int           W       = CNT_W,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   assign value = cnt_q;
   assign zero  = (cnt_q == '0);

   always_comb begin
      cnt_d = load ? load_val : (zero ? cnt_q : cnt_q - W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= RST_VAL;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: reset sequencer plus two-requester round-robin arbiter for the clock switcher.
// Define CLK_SWITCH_CTRL_TIMEOUT_EN to abort unacknowledged switch commands after TIMEOUT_CYCLES.
module clk_switch_ctrl
   import clk_switch_ctrl_pkg::*;
#(
   parameter int DIV_RST_CYCLES  = 8,
   parameter int SW_RST_CYCLES   = 8,
   parameter int CORE_RST_CYCLES = 32,
   parameter int DWELL_CYCLES    = 16,
   parameter int SEL_W           = 1,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   output logic             reset_clkdivider,
   output logic             reset_clkswitcher,
   output logic             reset_core,
   output logic             init_done,
   input  logic             req0_val,
   output logic             req0_rdy,
   input  logic [SEL_W-1:0] req0_msg,
   input  logic             req1_val,
   output logic             req1_rdy,
   input  logic [SEL_W-1:0] req1_msg,
   output logic             switch_val,
   input  logic             switch_rdy,
   output logic [SEL_W-1:0] switch_msg,
   output logic [SEL_W-1:0] cur_sel,
   output logic             busy,
   output logic             switch_err
);

   localparam int CW = cnt_width(DIV_RST_CYCLES, SW_RST_CYCLES, CORE_RST_CYCLES, DWELL_CYCLES, TIMEOUT_CYCLES);

   clk_switch_ctrl_state_e state_q, state_d;
   logic             ptr_q, ptr_d;
   logic [SEL_W-1:0] switch_msg_q, switch_msg_d;
   logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
   logic             switch_val_q, switch_val_d;
   logic             busy_q, busy_d;
   logic             rst_div_q, rst_div_d;
   logic             rst_sw_q, rst_sw_d;
   logic             rst_core_q, rst_core_d;
   logic             init_done_q, init_done_d;
   logic             cnt_load, cnt_zero;
   logic [CW-1:0]    cnt_load_val, cnt_val;
   logic             cnt_unused;
   logic             grant0, grant1, fire0, fire1;
   logic [SEL_W-1:0] fire_msg;

   clk_switch_ctrl_cnt #(
      .W       (CW),
      .RST_VAL (CW'(DIV_RST_CYCLES - 1))
   ) u_cnt (
      .clk      (clk),
      .rst_n    (reset_n),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .value    (cnt_val),
      .zero     (cnt_zero)
   );

   assign cnt_unused = ^cnt_val;

   // Pointer names the preferred requester when both are valid.
   assign grant0   = req0_val & (~req1_val | ~ptr_q);
   assign grant1   = req1_val & (~req0_val | ptr_q);
   assign req0_rdy = (state_q == IDLE) & grant0;
   assign req1_rdy = (state_q == IDLE) & grant1;
   assign fire0    = req0_val & req0_rdy;
   assign fire1    = req1_val & req1_rdy;
   assign fire_msg = fire0 ? req0_msg : req1_msg;

`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      switch_msg_d = switch_msg_q;
      cur_sel_d    = cur_sel_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
      err_d        = err_q;
`endif
      case (state_q)
         RST_DIV: if (cnt_zero) begin
            state_d      = RST_SW;
            cnt_load     = 1'b1;
            cnt_load_val = CW'(SW_RST_CYCLES - 1);
         end
         RST_SW: if (cnt_zero) begin
            state_d      = RST_CORE;
            cnt_load     = 1'b1;
            cnt_load_val = CW'(CORE_RST_CYCLES - 1);
         end
         RST_CORE: if (cnt_zero) state_d = IDLE;
         IDLE: if (fire0 | fire1) begin
            ptr_d = fire0;
            if (fire_msg != cur_sel_q) begin
               switch_msg_d = fire_msg;
               state_d      = ISSUE;
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
               cnt_load     = 1'b1;
               cnt_load_val = CW'(TIMEOUT_CYCLES - 1);
`endif
            end
         end
         ISSUE: if (switch_rdy) begin
            cur_sel_d    = switch_msg_q;
            state_d      = DWELL;
            cnt_load     = 1'b1;
            cnt_load_val = CW'(DWELL_CYCLES - 1);
         end
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
         else if (cnt_zero) begin
            err_d        = 1'b1;
            state_d      = DWELL;
            cnt_load     = 1'b1;
            cnt_load_val = CW'(DWELL_CYCLES - 1);
         end
`endif
         DWELL: if (cnt_zero) state_d = IDLE;
         default: state_d = RST_DIV;
      endcase
      switch_val_d = (state_d == ISSUE);
      busy_d       = (state_d == ISSUE) | (state_d == DWELL);
      rst_div_d    = (state_d == RST_DIV);
      rst_sw_d     = rst_div_d | (state_d == RST_SW);
      rst_core_d   = rst_sw_d | (state_d == RST_CORE);
      init_done_d  = ~rst_core_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= RST_DIV;
         ptr_q        <= 1'b0;
         switch_msg_q <= '0;
         cur_sel_q    <= '0;
         switch_val_q <= 1'b0;
         busy_q       <= 1'b0;
         rst_div_q    <= 1'b1;
         rst_sw_q     <= 1'b1;
         rst_core_q   <= 1'b1;
         init_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         switch_msg_q <= switch_msg_d;
         cur_sel_q    <= cur_sel_d;
         switch_val_q <= switch_val_d;
         busy_q       <= busy_d;
         rst_div_q    <= rst_div_d;
         rst_sw_q     <= rst_sw_d;
         rst_core_q   <= rst_core_d;
         init_done_q  <= init_done_d;
      end
   end

`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_q <= 1'b0;
      else          err_q <= err_d;
   end
   assign switch_err = err_q;
`else
   assign switch_err = 1'b0;
`endif

   assign reset_clkdivider  = rst_div_q;
   assign reset_clkswitcher = rst_sw_q;
   assign reset_core        = rst_core_q;
   assign init_done         = init_done_q;
   assign switch_val        = switch_val_q;
   assign switch_msg        = switch_msg_q;
   assign cur_sel           = cur_sel_q;
   assign busy              = busy_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: directed checks of reset sequencing, arbitration, dwell and backpressure.
module tb_clk_switch_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req0_val = 1'b0, req1_val = 1'b0, switch_rdy = 1'b0;
   logic [0:0] req0_msg = '0, req1_msg = '0;
   logic       reset_clkdivider, reset_clkswitcher, reset_core, init_done;
   logic       req0_rdy, req1_rdy, switch_val, busy, switch_err;
   logic [0:0] switch_msg, cur_sel;
   int         checks = 0;
   int         errors = 0;

   clk_switch_ctrl dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .reset_clkdivider  (reset_clkdivider),
      .reset_clkswitcher (reset_clkswitcher),
      .reset_core        (reset_core),
      .init_done         (init_done),
      .req0_val          (req0_val),
      .req0_rdy          (req0_rdy),
      .req0_msg          (req0_msg),
      .req1_val          (req1_val),
      .req1_rdy          (req1_rdy),
      .req1_msg          (req1_msg),
      .switch_val        (switch_val),
      .switch_rdy        (switch_rdy),
      .switch_msg        (switch_msg),
      .cur_sel           (cur_sel),
      .busy              (busy),
      .switch_err        (switch_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      repeat (2) tick;
      req0_val = 1'b1;
      req1_val = 1'b1;
      #1;
      checks++;
      if ({reset_clkdivider, reset_clkswitcher, reset_core, init_done} !== 4'b1110) begin
         errors++;
         $display("FAIL reset_outs got %b want 1110", {reset_clkdivider, reset_clkswitcher, reset_core, init_done});
      end
      checks++;
      if ({switch_val, switch_msg, cur_sel, busy, switch_err, req0_rdy, req1_rdy} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 0000000", {switch_val, switch_msg, cur_sel, busy, switch_err, req0_rdy, req1_rdy});
      end
      req0_val = 1'b0;
      req1_val = 1'b0;
   endtask

   task automatic test_poweron;
      @(posedge clk);
      #1;
      reset_n  = 1'b1;
      req0_val = 1'b1;
      req0_msg = 1'b0;
      for (int c = 1; c <= 48; c++) begin
         tick;
         checks++;
         if ({reset_clkdivider, reset_clkswitcher, reset_core, init_done} !== {c < 8, c < 16, c < 48, c >= 48}) begin
            errors++;
            $display("FAIL poweron_seq cycle %0d got %b want %b", c,
                     {reset_clkdivider, reset_clkswitcher, reset_core, init_done}, {c < 8, c < 16, c < 48, c >= 48});
         end
         checks++;
         if (req0_rdy !== (c == 48)) begin
            errors++;
            $display("FAIL poweron_rdy cycle %0d got %b want %b", c, req0_rdy, c == 48);
         end
      end
      req0_val = 1'b0;
   endtask

   task automatic test_single_switch;
      repeat (12) tick;
      req0_val   = 1'b1;
      req0_msg   = 1'b1;
      switch_rdy = 1'b1;
      #1;
      checks++;
      if (req0_rdy !== 1'b1) begin
         errors++;
         $display("FAIL single_grant got %b want 1", req0_rdy);
      end
      tick;
      checks++;
      if ({switch_val, switch_msg, busy, cur_sel} !== 4'b1110) begin
         errors++;
         $display("FAIL single_issue got %b want 1110", {switch_val, switch_msg, busy, cur_sel});
      end
      tick;
      checks++;
      if ({switch_val, busy, cur_sel, req0_rdy} !== 4'b0110) begin
         errors++;
         $display("FAIL single_commit got %b want 0110", {switch_val, busy, cur_sel, req0_rdy});
      end
      for (int c = 63; c <= 77; c++) begin
         tick;
         checks++;
         if ({req0_rdy, busy} !== 2'b01) begin
            errors++;
            $display("FAIL single_dwell cycle %0d got %b want 01", c, {req0_rdy, busy});
         end
      end
      tick;
      checks++;
      if ({req0_rdy, busy} !== 2'b10) begin
         errors++;
         $display("FAIL single_regrant got %b want 10", {req0_rdy, busy});
      end
      req0_val = 1'b0;
   endtask

   task automatic test_same_sel;
      req1_val = 1'b1;
      req1_msg = 1'b1;
      #1;
      checks++;
      if ({req1_rdy, req0_rdy} !== 2'b10) begin
         errors++;
         $display("FAIL same_grant got %b want 10", {req1_rdy, req0_rdy});
      end
      tick;
      req1_val = 1'b0;
      #1;
      checks++;
      if ({req1_rdy, switch_val, busy, cur_sel} !== 4'b0001) begin
         errors++;
         $display("FAIL same_drop got %b want 0001", {req1_rdy, switch_val, busy, cur_sel});
      end
   endtask

   task automatic test_simultaneous;
      logic [0:0] cmds [4];
      int n = 0, g0 = -1, g1 = -1;
      logic f0, f1;
      req0_val = 1'b1;
      req0_msg = 1'b0;
      req1_val = 1'b1;
      req1_msg = 1'b1;
      #1;
      checks++;
      if ({req0_rdy, req1_rdy} !== 2'b10) begin
         errors++;
         $display("FAIL sim_ptr got %b want 10", {req0_rdy, req1_rdy});
      end
      for (int i = 0; i < 40; i++) begin
         if (switch_val && switch_rdy) begin
            if (n < 4) cmds[n] = switch_msg;
            n++;
         end
         f0 = req0_val & req0_rdy;
         f1 = req1_val & req1_rdy;
         if (f0) g0 = i;
         if (f1) g1 = i;
         tick;
         if (f0) req0_val = 1'b0;
         if (f1) req1_val = 1'b0;
         #1;
      end
      checks++;
      if (g0 !== 0 || g1 !== 18) begin
         errors++;
         $display("FAIL sim_grants got %0d,%0d want 0,18", g0, g1);
      end
      checks++;
      if (n !== 2) begin
         errors++;
         $display("FAIL sim_count got %0d want 2", n);
      end
      checks++;
      if (n >= 2 && {cmds[0], cmds[1]} !== 2'b01) begin
         errors++;
         $display("FAIL sim_order got %b want 01", {cmds[0], cmds[1]});
      end
      checks++;
      if ({cur_sel, busy} !== 2'b10) begin
         errors++;
         $display("FAIL sim_final got %b want 10", {cur_sel, busy});
      end
   endtask

   task automatic test_backpressure;
      switch_rdy = 1'b0;
      req0_val   = 1'b1;
      req0_msg   = 1'b0;
      #1;
      checks++;
      if (req0_rdy !== 1'b1) begin
         errors++;
         $display("FAIL bp_grant got %b want 1", req0_rdy);
      end
      tick;
      req0_val = 1'b0;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if ({switch_val, switch_msg, busy, cur_sel} !== 4'b1011) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got %b want 1011", k, {switch_val, switch_msg, busy, cur_sel});
         end
         tick;
      end
      checks++;
      if (switch_err !== 1'b0) begin
         errors++;
         $display("FAIL bp_err got %b want 0", switch_err);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({reset_clkdivider, reset_clkswitcher, reset_core, init_done, switch_val, switch_msg, busy, cur_sel} !== 8'b11100000) begin
         errors++;
         $display("FAIL midop_reset got %b want 11100000",
                  {reset_clkdivider, reset_clkswitcher, reset_core, init_done, switch_val, switch_msg, busy, cur_sel});
      end
   endtask

`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
   task automatic test_timeout;
      req0_val = 1'b1;
      req0_msg = 1'b1;
      #1;
      tick;
      req0_val = 1'b0;
      repeat (63) tick;
      checks++;
      if ({switch_val, switch_err} !== 2'b10) begin
         errors++;
         $display("FAIL to_wait got %b want 10", {switch_val, switch_err});
      end
      tick;
      checks++;
      if ({switch_val, switch_err, cur_sel, busy} !== 4'b0101) begin
         errors++;
         $display("FAIL to_expire got %b want 0101", {switch_val, switch_err, cur_sel, busy});
      end
      repeat (20) tick;
      checks++;
      if ({switch_err, busy} !== 2'b10) begin
         errors++;
         $display("FAIL to_sticky got %b want 10", {switch_err, busy});
      end
   endtask
`endif

   initial begin
      test_reset;
      test_poweron;
      test_single_switch;
      test_same_sel;
      test_simultaneous;
      test_backpressure;
      test_poweron;
`ifdef CLK_SWITCH_CTRL_TIMEOUT_EN
      test_timeout;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
